// File: rtl/alu_stateful_v2.sv
// alu_stateful_v2 -- pipelined stateful ALU for one RMT stage.
//
// Executes one action per cycle against a private state RAM. Tenant pages
// (base/length) isolate RAM accesses. A RAM access outside the page, or one
// made while no page entry is valid, is flagged on overflow_out and does not
// write the RAM. Both sides use valid/ready handshakes.
//
// Pipeline:
//   S1  accept: register opcode, operands, physical address and overflow
//       flag, and issue the RAM read.
//   S2  RAM data is available: compute, write back, register the result.
//
// Ports:
//   clk, rst              stage clock, synchronous active-high reset
//   action_in             action word, opcode in the top 4 bits
//   action_valid          action and operands valid
//   operand_1_in          op1
//   operand_2_in          op2 / immediate / RAM offset
//   operand_3_in          passthrough container value
//   ready_out             action accepted when action_valid && ready_out
//   page_tbl_out          page entry {addr_len, base_addr}
//   page_tbl_out_valid    page entry valid
//   container_out         result
//   container_out_valid   result valid
//   overflow_out          isolation violation, qualifies container_out
//   ready_in              downstream ready
module alu_stateful_v2 #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int PAGE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  input  logic [DATA_WIDTH-1:0] operand_3_in,
  output logic                  ready_out,
  input  logic [2*PAGE_W-1:0]   page_tbl_out,
  input  logic                  page_tbl_out_valid,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  output logic                  overflow_out,
  input  logic                  ready_in
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = AW + PAGE_W;

  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_GEQ    = 4'b0110;
  localparam logic [3:0] OP_SET    = 4'b1110;
  localparam logic [3:0] OP_STORE  = 4'b1000;
  localparam logic [3:0] OP_STOREI = 4'b0011;
  localparam logic [3:0] OP_LOAD   = 4'b1011;
  localparam logic [3:0] OP_LOADD  = 4'b0111;
  localparam logic [3:0] OP_ITE    = 4'b0100;

  // ---------------------------------------------------------------------------
  // Accept-side decode
  // ---------------------------------------------------------------------------
  logic [3:0]        op_in;
  logic [AW-1:0]     offset_in;
  logic [PAGE_W-1:0] base_in;
  logic [PAGE_W-1:0] len_in;
  logic [AW-1:0]     phys_in;
  logic              ram_op_in;
  logic              ovf_in;

  assign op_in     = action_in[ACTION_LEN-1 -: 4];
  assign offset_in = operand_2_in[AW-1:0];
  assign base_in   = page_tbl_out[PAGE_W-1:0];
  assign len_in    = page_tbl_out[2*PAGE_W-1:PAGE_W];
  // Truncating to AW bits makes the address wrap modulo MEM_DEPTH.
  assign phys_in   = AW'(base_in) + offset_in;
  assign ram_op_in = (op_in == OP_STORE) || (op_in == OP_STOREI) ||
                     (op_in == OP_LOAD)  || (op_in == OP_LOADD)  ||
                     (op_in == OP_ITE);
  assign ovf_in    = ram_op_in &&
                     (!page_tbl_out_valid || (CW'(offset_in) > CW'(len_in)));

  // Lower action bits carry sub-action fields this block does not consume.
  logic unused_ok;
  assign unused_ok = (^action_in[ACTION_LEN-5:0]) ^ (STAGE_ID < 0);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic adv;
  logic container_out_valid_q;

  assign adv       = !container_out_valid_q || ready_in;
  assign ready_out = adv && !rst;

  // ---------------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------------
  logic                  s1_valid_q;
  logic [3:0]            s1_op_q;
  logic [DATA_WIDTH-1:0] s1_op1_q;
  logic [DATA_WIDTH-1:0] s1_op2_q;
  logic [DATA_WIDTH-1:0] s1_op3_q;
  logic [AW-1:0]         s1_addr_q;
  logic                  s1_ovf_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= action_valid;
    end
  end

  // Payload registers need no reset; they are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (adv && action_valid) begin
      s1_op_q   <= op_in;
      s1_op1_q  <= operand_1_in;
      s1_op2_q  <= operand_2_in;
      s1_op3_q  <= operand_3_in;
      s1_addr_q <= phys_in;
      s1_ovf_q  <= ovf_in;
    end
  end

  // ---------------------------------------------------------------------------
  // State RAM: 1 write / 1 registered read, plus same-edge write forwarding
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  we;

  // While stalled, keep re-reading the held S1 address so its data stays
  // current. No write can land during a stall, since writes need adv.
  assign rd_addr = adv ? phys_in : s1_addr_q;
  assign we      = adv && s1_valid_q && !rst && wr_en_d;

  // NOTE: the RAM array is deliberately not reset; state survives rst and
  // a resettable array would not map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[s1_addr_q] <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q       <= mem[rd_addr];
    fwd_q      <= we && (s1_addr_q == rd_addr);
    fwd_data_q <= wr_data_d;
  end

  // A write on the same edge as the read wins over the stale array word.
  assign rd_data = fwd_q ? fwd_data_q : rd_q;

  // ---------------------------------------------------------------------------
  // S2 compute
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_plus1;
  logic [DATA_WIDTH-1:0] ram_res;
  logic [DATA_WIDTH-1:0] res_d;

  assign mem_plus1 = rd_data + DATA_WIDTH'(1);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    res_d     = s1_op3_q;
    wr_en_d   = 1'b0;
    wr_data_d = s1_op1_q;
    ram_res   = s1_ovf_q ? '0 : rd_data;
    case (s1_op_q)
      OP_ADD, OP_ADDI: res_d = s1_op1_q + s1_op2_q;
      OP_SUB, OP_SUBI: res_d = s1_op1_q - s1_op2_q;
      OP_OR:  res_d = {{(DATA_WIDTH-1){1'b0}}, (s1_op1_q != '0) || (s1_op2_q != '0)};
      OP_GEQ: res_d = {{(DATA_WIDTH-1){1'b0}}, s1_op1_q >= s1_op2_q};
      OP_SET: res_d = s1_op2_q;
      OP_STORE, OP_STOREI: begin
        wr_en_d   = !s1_ovf_q;
        wr_data_d = s1_op1_q;
      end
      OP_LOAD: res_d = ram_res;
      OP_LOADD: begin
        wr_en_d   = !s1_ovf_q;
        wr_data_d = mem_plus1;
        res_d     = s1_ovf_q ? '0 : mem_plus1;
      end
      OP_ITE: begin
        wr_en_d = !s1_ovf_q;
        if (s1_op1_q == '0) begin
          wr_data_d = mem_plus1;
          res_d     = s1_ovf_q ? '0 : mem_plus1;
        end else begin
          wr_data_d = s1_op3_q;
        end
      end
      default: res_d = s1_op3_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] container_out_q;
  logic                  overflow_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      container_out_valid_q <= 1'b0;
      container_out_q       <= '0;
      overflow_out_q        <= 1'b0;
    end else if (adv) begin
      container_out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        container_out_q <= res_d;
        overflow_out_q  <= s1_ovf_q;
      end
    end
  end

  assign container_out       = container_out_q;
  assign container_out_valid = container_out_valid_q;
  assign overflow_out        = overflow_out_q;

endmodule

// File: tb/tb_alu_stateful_v2.sv
// Self-checking bench for alu_stateful_v2: directed scenarios plus a random
// stream, scored against an in-order behavioural model of the RAM and ALU.
module tb_alu_stateful_v2;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AL    = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic [AL-1:0] action_in;
  logic          action_valid;
  logic [DW-1:0] operand_1_in, operand_2_in, operand_3_in;
  logic          ready_out;
  logic [15:0]   page_tbl_out;
  logic          page_tbl_out_valid;
  logic [DW-1:0] container_out;
  logic          container_out_valid;
  logic          overflow_out;
  logic          ready_in;

  always #5 clk = ~clk;

  alu_stateful_v2 #(
    .STAGE_ID(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .PAGE_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .action_in(action_in), .action_valid(action_valid),
    .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
    .ready_out(ready_out),
    .page_tbl_out(page_tbl_out), .page_tbl_out_valid(page_tbl_out_valid),
    .container_out(container_out), .container_out_valid(container_out_valid),
    .overflow_out(overflow_out), .ready_in(ready_in)
  );

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          addr;
    logic [31:0] old;
    bit          wrote;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_total = 0;
  int          n_bad   = 0;

  // Handshake history for the latency and hold checks.
  bit          acc_p1 = 0, acc_p2 = 0, adv_p1 = 0, hold_p = 0;
  logic [31:0] prev_out;
  logic        prev_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: actions take effect in acceptance order on a plain array.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, b, c,
                            input logic [15:0] page, input logic pv, output exp_t e);
    int offset, phys, len, base;
    bit ram_op, ovf;
    base   = int'(page[7:0]);
    len    = int'(page[15:8]);
    offset = int'(b % DEPTH);
    phys   = (base + offset) % DEPTH;
    ram_op = op inside {4'b1000, 4'b0011, 4'b1011, 4'b0111, 4'b0100};
    ovf    = ram_op && (!pv || offset > len);
    e.ovf = ovf; e.addr = phys; e.old = ref_mem[phys]; e.wrote = 0; e.data = c;
    case (op)
      4'b0001, 4'b1001: e.data = a + b;
      4'b0010, 4'b1010: e.data = a - b;
      4'b0101: e.data = ((a != 0) || (b != 0)) ? 32'd1 : 32'd0;
      4'b0110: e.data = (a >= b) ? 32'd1 : 32'd0;
      4'b1110: e.data = b;
      4'b1000, 4'b0011: if (!ovf) begin ref_mem[phys] = a; e.wrote = 1; end
      4'b1011: e.data = ovf ? 32'd0 : ref_mem[phys];
      4'b0111: begin
        if (ovf) e.data = 0;
        else begin ref_mem[phys] = ref_mem[phys] + 1; e.wrote = 1; e.data = ref_mem[phys]; end
      end
      4'b0100: begin
        if (a == 0) begin
          if (ovf) e.data = 0;
          else begin ref_mem[phys] = ref_mem[phys] + 1; e.wrote = 1; e.data = ref_mem[phys]; end
        end else if (!ovf) begin
          ref_mem[phys] = c; e.wrote = 1;
        end
      end
      default: e.data = c;
    endcase
  endtask

  // One clock: sample at the falling edge, score, then advance past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    int   start;
    bit   acc_now, adv_now;
    @(negedge clk);
    if (hold_p) begin
      check("hold_data", container_out, prev_out);
      check("hold_ovf", overflow_out, prev_ovf);
    end
    if (acc_p2 && adv_p1) check("latency_valid", container_out_valid, 1);
    if (container_out_valid === 1'b1 && ready_in && !rst) check("stall_ready", ready_out, 32'(adv_p1 | 1'b1) & 0 | 32'(ready_in));
    if (container_out_valid === 1'b1 && !ready_in && !rst) check("stall_ready_low", ready_out, 0);
    if (rst) check("rst_ready", ready_out, 0);
    if (container_out_valid === 1'b1 && ready_in) begin
      if (exp_q.size() == 0) check("spurious_out", container_out_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("out_data", container_out, e.data);
        check("out_ovf", overflow_out, e.ovf);
      end
    end
    acc_now = action_valid && (ready_out === 1'b1);
    if (acc_now) begin
      model_exec(action_in[AL-1 -: 4], operand_1_in, operand_2_in, operand_3_in,
                 page_tbl_out, page_tbl_out_valid, e);
      exp_q.push_back(e);
    end
    if (rst) begin
      // A result held in the output register already wrote the RAM; anything
      // still in S1 is dropped without a write.
      start = (container_out_valid === 1'b1 && !ready_in) ? 1 : 0;
      for (int i = exp_q.size() - 1; i >= start; i--)
        if (exp_q[i].wrote) ref_mem[exp_q[i].addr] = exp_q[i].old;
      exp_q.delete();
    end
    adv_now  = ((container_out_valid !== 1'b1) || ready_in) && !rst;
    acc_p2   = acc_p1;
    acc_p1   = acc_now;
    adv_p1   = adv_now;
    hold_p   = (container_out_valid === 1'b1) && !ready_in && !rst;
    prev_out = container_out;
    prev_ovf = overflow_out;
    acc      = acc_now;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, b, c);
    bit acc;
    int n;
    action_valid = 1'b1;
    action_in    = {op, 21'($urandom)};
    operand_1_in = a; operand_2_in = b; operand_3_in = c;
    acc = 0; n = 0;
    while (!acc && n < 50) begin tick(acc); n++; end
    if (!acc) check("accept_timeout", 32'(acc), 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    action_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    action_valid = 1'b0;
    ready_in     = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || container_out_valid === 1'b1) && n < 50) begin tick(acc); n++; end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic set_page(input int len, input int base, input logic v);
    page_tbl_out       = {8'(len), 8'(base)};
    page_tbl_out_valid = v;
  endtask

  initial begin
    bit acc;
    rst = 1'b1; ready_in = 1'b1; action_valid = 1'b0; action_in = '0;
    operand_1_in = '0; operand_2_in = '0; operand_3_in = '0;
    set_page(31, 0, 1'b1);

    // Reset state.
    idle(2);
    check("rst_valid", container_out_valid, 0);
    check("rst_data", container_out, 0);
    check("rst_ovf", overflow_out, 0);
    check("rst_ready_out", ready_out, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", ready_out, 1);

    // Fill the RAM so every later read has a known value.
    for (int i = 0; i < DEPTH; i++) send(4'b1000, 32'(i * 3 + 1), 32'(i), 32'hC0DE);
    drain();

    // Store then back-to-back loads of the same word.
    send(4'b1000, 32'hAB, 5, 32'h55);
    send(4'b1011, 0, 5, 0);
    send(4'b1011, 0, 5, 0);
    drain();

    // Three loadd from mem=7: 8, 9, 10, then read back 10.
    send(4'b0011, 7, 3, 0);
    send(4'b0111, 0, 3, 0);
    send(4'b0111, 0, 3, 0);
    send(4'b0111, 0, 3, 0);
    send(4'b1011, 0, 3, 0);
    drain();

    // Page isolation.
    send(4'b1000, 32'h1414, 14, 0);
    send(4'b1000, 32'h1212, 12, 0);
    set_page(4, 8, 1'b1);
    send(4'b1000, 32'hDEAD, 6, 32'h66);   // offset 6 > len 4
    send(4'b1011, 0, 4, 32'h77);          // offset 4 == len: mem[12]
    send(4'b0111, 0, 5, 32'h88);          // overflow, RAM-sourced -> 0
    set_page(31, 0, 1'b0);
    send(4'b1011, 0, 1, 32'h99);          // no valid page -> overflow
    set_page(31, 0, 1'b1);
    send(4'b1011, 0, 14, 0);              // mem[14] untouched
    drain();

    // Downstream stall with two actions in flight.
    send(4'b1000, 100, 2, 0);
    drain();
    send(4'b0111, 0, 2, 0);
    send(4'b0111, 0, 2, 0);
    ready_in     = 1'b0;
    action_in    = {4'b1011, 21'd0};
    operand_2_in = 2;
    for (int i = 0; i < 5; i++) tick(acc);
    ready_in = 1'b1;
    send(4'b1011, 0, 2, 0);
    drain();

    // Arithmetic boundaries and ite.
    send(4'b0001, 32'hFFFF_FFFF, 2, 0);
    send(4'b1010, 0, 1, 0);
    send(4'b0110, 5, 5, 0);
    send(4'b0110, 4, 5, 0);
    send(4'b0101, 0, 0, 0);
    send(4'b1110, 0, 32'h1234_5678, 0);
    send(4'b1000, 4, 9, 0);
    send(4'b0100, 0, 9, 32'h33);          // mem 4 -> 5
    send(4'b0100, 1, 9, 9);               // mem <- 9
    send(4'b1011, 0, 9, 0);
    send(4'b1111, 0, 0, 32'hFEED);
    drain();

    // Reset with loadd in flight: dropped, no write.
    send(4'b1000, 20, 1, 0);
    drain();
    send(4'b0111, 0, 1, 0);
    action_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    check("rst_drop_valid", container_out_valid, 0);
    idle(2);
    check("rst_drop_quiet", container_out_valid, 0);
    send(4'b1011, 0, 1, 0);
    drain();

    // Random traffic with random backpressure and pages.
    acc = 1;
    action_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ready_in = ($urandom_range(0, 3) != 0);
      if (!action_valid || acc) begin
        action_valid = ($urandom_range(0, 3) != 0);
        action_in    = AL'($urandom);
        operand_1_in = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
        operand_2_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
        operand_3_in = $urandom;
        set_page($urandom_range(0, 40), $urandom_range(0, 255), $urandom_range(0, 9) != 0);
      end
      tick(acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
